// File: rtl/pong_neopix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : pong_neopix_pkg                                        |
// | Description : Shared types and constants for the Pong strip frame    |
// |               sequencer and its pixel colour generator.              |
// |   NUM_PIX      strip length (index is 5 bits, so at most 32)         |
// |   PADDLE_W     paddle length in pixels                               |
// |   BALL_LVL     per-channel ball intensity (white)                    |
// |   PAD_LVL      paddle intensity (red left, blue right)               |
// |   BUSY_TIMEOUT cycles after go within which ctrl_ready must fall     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pong_neopix_pkg;

  localparam int         NUM_PIX      = 32;
  localparam int         PADDLE_W     = 4;
  localparam logic [7:0] BALL_LVL     = 8'd16;
  localparam logic [7:0] PAD_LVL      = 8'd16;
  localparam int         BUSY_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_GO        = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // A position at or beyond the strip end lights nothing.
  function automatic logic on_strip(input logic [4:0] pos);
    return {1'b0, pos} < 6'(NUM_PIX);
  endfunction

  // Paddle span test done in 6 bits so a paddle near the end clips at the
  // last pixel instead of wrapping round to index 0.
  function automatic logic in_span(input logic [4:0] idx, input logic [4:0] start);
    logic [5:0] w_lo;
    logic [5:0] w_hi;
    logic [5:0] w_i;
    w_lo = {1'b0, start};
    w_hi = w_lo + 6'(PADDLE_W - 1);
    w_i  = {1'b0, idx};
    return on_strip(start) && (w_i >= w_lo) && (w_i <= w_hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_color_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pixel_color_gen                                        |
// | Description : Combinational colour of one strip pixel from the      |
// |               position snapshot. Priority: ball > left paddle >      |
// |               right paddle > background (dark).                      |
// |   idx    in  5   pixel index                                         |
// |   ball   in  5   ball pixel index                                    |
// |   pad_l  in  5   left paddle start index                             |
// |   pad_r  in  5   right paddle start index                            |
// |   color  out rgb colour for idx                                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pixel_color_gen
  import pong_neopix_pkg::*;
(
  input  logic [4:0] idx,
  input  logic [4:0] ball,
  input  logic [4:0] pad_l,
  input  logic [4:0] pad_r,
  output rgb_t       color
);

  logic w_ball_hit;
  logic w_left_hit;
  logic w_right_hit;

  assign w_ball_hit  = on_strip(ball) && (idx == ball);
  assign w_left_hit  = in_span(idx, pad_l);
  assign w_right_hit = in_span(idx, pad_r);

  always_comb begin
    color = '0;
    if (w_ball_hit) begin
      color.red   = BALL_LVL;
      color.green = BALL_LVL;
      color.blue  = BALL_LVL;
    end else if (w_left_hit) begin
      color.red = PAD_LVL;
    end else if (w_right_hit) begin
      color.blue = PAD_LVL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_strip_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pong_strip_scheduler                                   |
// | Description : Frame sequencer and sole master of the Neopixel        |
// |               controller load/go interface. On a frame request it    |
// |               snapshots ball/paddle positions, loads all pixels in   |
// |               index order, issues one go and waits for completion.   |
// |   CLOCK_50    in   system clock (rising edge)                        |
// |   reset_n     in   asynchronous active-low reset                     |
// |   enable      in   allows new frames to start                        |
// |   frame_tick  in   one-cycle frame request                           |
// |   ball_pos, pad_l_pos, pad_r_pos  in  5  positions                   |
// |   clear_err   in   clears sticky flags                               |
// |   ctrl_ready  in   controller ready                                  |
// |   pix_red/green/blue out 8, pix_index out 5, pix_load, pix_go out    |
// |   busy, frame_done, overrun, timeout_err  out  status                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pong_strip_scheduler
  import pong_neopix_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [4:0] ball_pos,
  input  logic [4:0] pad_l_pos,
  input  logic [4:0] pad_r_pos,
  input  logic       clear_err,
  input  logic       ctrl_ready,
  output logic [7:0] pix_red,
  output logic [7:0] pix_green,
  output logic [7:0] pix_blue,
  output logic [4:0] pix_index,
  output logic       pix_load,
  output logic       pix_go,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       timeout_err
);

  state_t     r_state;
  logic [4:0] r_idx;
  logic [4:0] r_ball;
  logic [4:0] r_pad_l;
  logic [4:0] r_pad_r;
  logic [4:0] r_cnt;
  logic       r_load;
  logic       r_go;
  logic       r_busy;
  logic       r_done;
  logic       r_overrun;
  logic       r_timeout;
  rgb_t       r_color;

  logic [4:0] w_gen_idx;
  logic [4:0] w_gen_ball;
  logic [4:0] w_gen_pl;
  logic [4:0] w_gen_pr;
  rgb_t       w_gen_color;
  logic       w_start;
  logic       w_last;

  assign w_start = (r_state == ST_IDLE) && frame_tick && enable && ctrl_ready;
  assign w_last  = (r_idx == 5'(NUM_PIX - 1));

  // The colour register always holds the colour of the pixel being
  // presented, so the generator looks one index ahead. When a frame starts
  // the snapshot is not yet registered, hence the live positions are used
  // to produce pixel 0.
  always_comb begin
    w_gen_idx  = r_idx + 5'd1;
    w_gen_ball = r_ball;
    w_gen_pl   = r_pad_l;
    w_gen_pr   = r_pad_r;
    if (r_state == ST_IDLE) begin
      w_gen_idx  = 5'd0;
      w_gen_ball = ball_pos;
      w_gen_pl   = pad_l_pos;
      w_gen_pr   = pad_r_pos;
    end
  end

  pixel_color_gen u_color (
    .idx   (w_gen_idx),
    .ball  (w_gen_ball),
    .pad_l (w_gen_pl),
    .pad_r (w_gen_pr),
    .color (w_gen_color)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ball    <= '0;
      r_pad_l   <= '0;
      r_pad_r   <= '0;
      r_cnt     <= '0;
      r_load    <= 1'b0;
      r_go      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_color   <= '0;
    end else begin
      r_go   <= 1'b0;
      r_done <= 1'b0;

      // Sticky flags: a set in the same cycle as clear_err wins.
      if (frame_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
      if (clear_err) begin
        r_timeout <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ball  <= ball_pos;
            r_pad_l <= pad_l_pos;
            r_pad_r <= pad_r_pos;
            r_idx   <= '0;
            r_color <= w_gen_color;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Without ctrl_ready everything holds: a stall, not a drop.
          if (ctrl_ready) begin
            if (w_last) begin
              r_load  <= 1'b0;
              r_go    <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_GO;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_color <= w_gen_color;
            end
          end
        end
        ST_GO: begin
          // r_cnt counts cycles since go was presented.
          r_cnt   <= r_cnt + 5'd1;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!ctrl_ready) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_cnt == 5'(BUSY_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (ctrl_ready) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix_red     = r_color.red;
  assign pix_green   = r_color.green;
  assign pix_blue    = r_color.blue;
  assign pix_index   = r_idx;
  assign pix_load    = r_load;
  assign pix_go      = r_go;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pong_strip_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pong_strip_scheduler                                |
// | Description : Self-checking bench for pong_strip_scheduler. Drives   |
// |               frames against a simple model of the strip picture and |
// |               the controller handshake timing.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pong_strip_scheduler;

  localparam int NPIX = 32;
  localparam int PADW = 4;
  localparam int TOUT = 16;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic [4:0] ball_pos = '0;
  logic [4:0] pad_l_pos = '0;
  logic [4:0] pad_r_pos = '0;
  logic       clear_err = 1'b0;
  logic       ctrl_ready = 1'b0;
  logic [7:0] pix_red, pix_green, pix_blue;
  logic [4:0] pix_index;
  logic       pix_load, pix_go, busy, frame_done, overrun, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  pong_strip_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .ball_pos    (ball_pos),
    .pad_l_pos   (pad_l_pos),
    .pad_r_pos   (pad_r_pos),
    .clear_err   (clear_err),
    .ctrl_ready  (ctrl_ready),
    .pix_red     (pix_red),
    .pix_green   (pix_green),
    .pix_blue    (pix_blue),
    .pix_index   (pix_index),
    .pix_load    (pix_load),
    .pix_go      (pix_go),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  // Picture model: {red, green, blue} of pixel i.
  function automatic logic [23:0] ref_col(input int i, input int b, input int l, input int r);
    if (b < NPIX && i == b) return {8'd16, 8'd16, 8'd16};
    if (l < NPIX && i >= l && i <= l + PADW - 1) return {8'd16, 8'd0, 8'd0};
    if (r < NPIX && i >= r && i <= r + PADW - 1) return {8'd0, 8'd0, 8'd16};
    return 24'd0;
  endfunction

  // One complete frame with an optional load stall, an optional extra
  // tick (with optional clear_err alongside) and either a normal
  // controller busy period of low_len cycles or no busy at all (timeout).
  task automatic run_frame(input int b, input int l, input int r,
                           input int stall_at, input int stall_len,
                           input int low_len, input int tick_at,
                           input bit clr_at_tick, input bit exp_timeout,
                           input string tag);
    int cyc;
    int loads;
    int scnt;
    logic [23:0] col;
    @(negedge CLOCK_50);
    ball_pos   = 5'(b);
    pad_l_pos  = 5'(l);
    pad_r_pos  = 5'(r);
    enable     = 1'b1;
    ctrl_ready = 1'b1;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    // Mid-frame input changes must not alter the picture or the frame.
    ball_pos  = 5'($urandom);
    pad_l_pos = 5'($urandom);
    pad_r_pos = 5'($urandom);
    enable    = 1'($urandom_range(0, 1));
    cyc = 1;
    loads = 0;
    scnt = 0;
    while (loads < NPIX && cyc < 300) begin
      col = ref_col(loads, b, l, r);
      n_cmp++;
      if ({pix_load, pix_go, busy, pix_index, pix_red, pix_green, pix_blue} !==
          {3'b101, 5'(loads), col}) begin
        n_err++;
        $display("FAIL %s load cyc=%0d: got load=%b go=%b busy=%b idx=%0d rgb=%h, want load=1 go=0 busy=1 idx=%0d rgb=%h",
                 tag, cyc, pix_load, pix_go, busy, pix_index, {pix_red, pix_green, pix_blue}, loads, col);
      end
      frame_tick = (cyc == tick_at);
      clear_err  = clr_at_tick && (cyc == tick_at);
      if (loads == stall_at && scnt < stall_len) begin
        ctrl_ready = 1'b0;
        scnt++;
      end else begin
        ctrl_ready = 1'b1;
        loads++;
      end
      @(negedge CLOCK_50);
      cyc++;
    end
    frame_tick = 1'b0;
    clear_err  = 1'b0;
    n_cmp++;
    if ({pix_go, pix_load, busy} !== 3'b101) begin
      n_err++;
      $display("FAIL %s go cyc=%0d: got go=%b load=%b busy=%b, want go=1 load=0 busy=1",
               tag, cyc, pix_go, pix_load, busy);
    end
    if (exp_timeout) begin
      ctrl_ready = 1'b1;
      for (int k = 1; k <= TOUT; k++) begin
        @(negedge CLOCK_50);
        n_cmp++;
        if ({timeout_err, busy, frame_done, pix_go, pix_load} !==
            {(k == TOUT), (k < TOUT), 3'b000}) begin
          n_err++;
          $display("FAIL %s timeout go+%0d: got terr=%b busy=%b done=%b go=%b load=%b, want terr=%b busy=%b done=0 go=0 load=0",
                   tag, k, timeout_err, busy, frame_done, pix_go, pix_load, (k == TOUT), (k < TOUT));
        end
      end
    end else begin
      ctrl_ready = 1'b0;
      for (int k = 1; k <= low_len + 2; k++) begin
        @(negedge CLOCK_50);
        n_cmp++;
        if ({frame_done, busy, pix_go, pix_load, timeout_err} !==
            {(k == low_len + 1), (k <= low_len), 3'b000}) begin
          n_err++;
          $display("FAIL %s done go+%0d: got done=%b busy=%b go=%b load=%b terr=%b, want done=%b busy=%b go=0 load=0 terr=0",
                   tag, k, frame_done, busy, pix_go, pix_load, timeout_err, (k == low_len + 1), (k <= low_len));
        end
        if (k == low_len) ctrl_ready = 1'b1;
      end
    end
    enable = 1'b1;
    ctrl_ready = 1'b1;
  endtask

  task automatic pulse_clear();
    @(negedge CLOCK_50);
    clear_err = 1'b1;
    @(negedge CLOCK_50);
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({pix_red, pix_green, pix_blue, pix_index, pix_load, pix_go, busy, frame_done, overrun, timeout_err} !== 35'd0) begin
      n_err++;
      $display("FAIL reset: got outputs=%h, want 0",
               {pix_red, pix_green, pix_blue, pix_index, pix_load, pix_go, busy, frame_done, overrun, timeout_err});
    end
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    ctrl_ready = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(5, 0, 28, -1, 0, 10, -1, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_clip();
    run_frame(3, 2, 30, -1, 0, 4, -1, 1'b0, 1'b0, "clip");
  endtask

  task automatic test_stall();
    run_frame(20, 9, 14, 7, 3, 5, -1, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_drop();
    @(negedge CLOCK_50);
    enable = 1'b0;
    ctrl_ready = 1'b1;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    n_cmp++;
    if ({busy, pix_load, overrun} !== 3'b000) begin
      n_err++;
      $display("FAIL drop_enable: got busy=%b load=%b ovr=%b, want 0 0 0", busy, pix_load, overrun);
    end
    enable = 1'b1;
    ctrl_ready = 1'b0;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    ctrl_ready = 1'b1;
    n_cmp++;
    if ({busy, pix_load, overrun} !== 3'b000) begin
      n_err++;
      $display("FAIL drop_ready: got busy=%b load=%b ovr=%b, want 0 0 0", busy, pix_load, overrun);
    end
  endtask

  task automatic test_overrun();
    run_frame(11, 6, 24, -1, 0, 3, 10, 1'b0, 1'b0, "ovr1");
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %b, want 1", overrun);
    end
    pulse_clear();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: got %b, want 0", overrun);
    end
    run_frame(17, 16, 1, -1, 0, 3, 10, 1'b1, 1'b0, "ovr2");
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set_wins: got %b, want 1", overrun);
    end
    pulse_clear();
  endtask

  task automatic test_timeout();
    run_frame(0, 12, 20, -1, 0, 0, -1, 1'b0, 1'b1, "tout");
    repeat (3) @(negedge CLOCK_50);
    n_cmp++;
    if ({timeout_err, busy, frame_done} !== 3'b100) begin
      n_err++;
      $display("FAIL timeout_sticky: got terr=%b busy=%b done=%b, want 1 0 0", timeout_err, busy, frame_done);
    end
    pulse_clear();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: got %b, want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    bit saw_go;
    @(negedge CLOCK_50);
    ball_pos = 5'd12;
    pad_l_pos = 5'd4;
    pad_r_pos = 5'd25;
    ctrl_ready = 1'b1;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    guard = 0;
    while (!(pix_load === 1'b1 && pix_index === 5'd12) && guard < 40) begin
      @(negedge CLOCK_50);
      guard++;
    end
    n_cmp++;
    if (guard >= 40) begin
      n_err++;
      $display("FAIL reset_mid_reach: got idx=%0d load=%b, want idx=12 load=1", pix_index, pix_load);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({pix_red, pix_green, pix_blue, pix_index, pix_load, pix_go, busy, frame_done, overrun, timeout_err} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got outputs=%h, want 0",
               {pix_red, pix_green, pix_blue, pix_index, pix_load, pix_go, busy, frame_done, overrun, timeout_err});
    end
    saw_go = 1'b0;
    repeat (4) begin
      @(negedge CLOCK_50);
      if (pix_go === 1'b1 || pix_load === 1'b1) saw_go = 1'b1;
    end
    n_cmp++;
    if (saw_go) begin
      n_err++;
      $display("FAIL reset_mid_hold: got go/load activity=1, want 0");
    end
    reset_n = 1'b1;
    run_frame(31, 28, 29, -1, 0, 2, -1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(0, NPIX - 1)), int'($urandom_range(0, NPIX - 1)),
                int'($urandom_range(0, NPIX - 1)), int'($urandom_range(0, NPIX - 1)),
                int'($urandom_range(0, 4)), int'($urandom_range(2, 12)), -1,
                1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_stall();
    test_drop();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
